hit_writer: RTL and testbench
=============================

HIT_WRITER -- requirements
Module: hit_writer

Interface
REQ-001 SHALL have parameter NDWORDS, default 3; 32-bit dwords per record written.
REQ-002 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port baseaddr  input  32  byte base address of result buffer; sampled on accept.
REQ-005 SHALL have port index  input  32  record index; sampled on accept.
REQ-006 SHALL have port write  input  1  request to write one record.
REQ-007 SHALL have port data  input  32*NDWORDS  record payload; dword k occupies bits [32k+31:32k]; sampled on accept.
REQ-008 SHALL have port oready  output  1  high when a new record can be accepted.
REQ-009 SHALL have port odone  output  1  one-cycle pulse when the last halfword of a record is accepted by memory.
REQ-010 SHALL have port o_wr_count  output  32  completed-record count (see Configuration).
REQ-011 SHALL have AVMM master ports: avm_m0_write out 1; avm_m0_address out 32; avm_m0_writedata out 16; avm_m0_byteenable out 2; avm_m0_waitrequest in 1.

Function
REQ-012 SHALL implement FSM states IDLE and WRITE; oready = (state == IDLE).
REQ-013 Accept = write && oready at a rising edge; SHALL capture data, compute start address baseaddr + index*NDWORDS*4 (modulo 2^32, wrap silently), clear halfword counter hw to 0, enter WRITE.
REQ-014 write while not in IDLE SHALL be ignored; no capture, no queueing.
REQ-015 In WRITE, avm_m0_write SHALL be 1, avm_m0_byteenable 2'b11, avm_m0_address = start + 2*hw, avm_m0_writedata = halfword hw of captured record (hw even: low 16 bits of dword hw/2; hw odd: high 16 bits).
REQ-016 Address, writedata, byteenable SHALL stay stable while avm_m0_waitrequest is 1; hw advances only on a cycle with avm_m0_write=1 and waitrequest=0.
REQ-017 Halfwords SHALL be written in order hw = 0 .. 2*NDWORDS-1; total 2*NDWORDS bus writes per record.
REQ-018 When halfword 2*NDWORDS-1 is accepted, FSM SHALL return to IDLE and odone SHALL be 1 in the following cycle only.
REQ-019 Latency: avm_m0_write asserts the cycle after accept; with waitrequest tied 0, record completes in 2*NDWORDS cycles and oready returns on cycle 2*NDWORDS+1 after accept.
REQ-020 In IDLE, avm_m0_write SHALL be 0; address/writedata are don't-care but SHALL hold last values.
REQ-021 waitrequest held high indefinitely SHALL stall in WRITE with no timeout.
REQ-022 Captured record SHALL be unaffected by changes on data/baseaddr/index after accept.

Reset
REQ-023 i_rstn low SHALL immediately (asynchronously) force IDLE, avm_m0_write=0, avm_m0_address=0, avm_m0_writedata=0, avm_m0_byteenable=0, odone=0, o_wr_count=0, hw=0.
REQ-024 Reset mid-record SHALL abandon the record; no further halfwords written after reset release; oready=1 the first cycle after release.

Configuration
REQ-025 Macro HIT_WRITER_CNT_EN: when defined, o_wr_count SHALL increment by 1 (wrapping at 2^32) in the cycle odone pulses; when undefined, o_wr_count SHALL be constant 0 and no counter register synthesized.

Verification (NDWORDS=3)
REQ-026 baseaddr=0x1000, index=2, data dwords {0x00000001, 0x00018000, 0x00000007}, waitrequest=0 -> writes to 0x1018,0x101A,0x101C,0x101E,0x1020,0x1022 with data 0x0001,0x0000,0x8000,0x0001,0x0007,0x0000; odone one cycle; oready back at cycle 7.
REQ-027 Same record, waitrequest high for 3 cycles on halfword 2 -> address 0x101C/data 0x8000 held 4 cycles; sequence otherwise identical; completion delayed 3 cycles.
REQ-028 write asserted continuously for 3 records -> exactly 3 records of 6 writes each, no overlap; odone pulses 3 times; o_wr_count=3 with HIT_WRITER_CNT_EN, 0 without.
REQ-029 baseaddr=0xFFFFFFF8, index=0 -> addresses 0xFFFFFFF8,0xFFFFFFFA,0xFFFFFFFC,0xFFFFFFFE,0x00000000,0x00000002.
REQ-030 i_rstn pulsed low after 2nd halfword accepted -> avm_m0_write drops same cycle, no odone, no further writes, oready=1 after release, next record written correctly from hw 0.

Source files
------------

// File: rtl/hit_writer.sv
// Writes one NDWORDS-dword record as 2*NDWORDS consecutive 16-bit AVMM writes.
// Optional completed-record counter enabled by defining HIT_WRITER_CNT_EN.
module hit_writer #(
  parameter int NDWORDS = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [31:0]            baseaddr,
  input  logic [31:0]            index,
  input  logic                   write,
  input  logic [32*NDWORDS-1:0]  data,
  output logic                   oready,
  output logic                   odone,
  output logic [31:0]            o_wr_count,
  output logic                   avm_m0_write,
  output logic [31:0]            avm_m0_address,
  output logic [15:0]            avm_m0_writedata,
  output logic [1:0]             avm_m0_byteenable,
  input  logic                   avm_m0_waitrequest
);

  localparam int              NHW     = 2 * NDWORDS;
  localparam int              HW_W    = (NHW > 2) ? $clog2(NHW) : 1;
  localparam logic [HW_W-1:0] HW_LAST = HW_W'(NHW - 1);
  localparam logic [31:0]     STRIDE  = 32'(NDWORDS * 4);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [HW_W-1:0]       hw_q, hw_d;
  logic [32*NDWORDS-1:0] rec_q, rec_d;
  logic [31:0]           addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [1:0]            be_q, be_d;
  logic                  wr_q, wr_d;
  logic                  done_q, done_d;
  logic                  hw_accept;

  // A halfword is taken by the slave only when it is not stalling us.
  assign hw_accept = wr_q && !avm_m0_waitrequest;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      hw_q    <= '0;
      rec_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hw_q    <= hw_d;
      rec_q   <= rec_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
    end
  end

  // rec_q is a shift register whose low halfword is always the one on the bus.
  always_comb begin
    state_d = state_q;
    hw_d    = hw_q;
    rec_d   = rec_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (write) begin
          state_d = WRITE;
          hw_d    = '0;
          rec_d   = data;
          addr_d  = baseaddr + index * STRIDE;
          wdata_d = data[15:0];
          be_d    = 2'b11;
          wr_d    = 1'b1;
        end
      end
      WRITE: begin
        if (hw_accept) begin
          if (hw_q == HW_LAST) begin
            state_d = IDLE;
            wr_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            hw_d    = hw_q + HW_W'(1);
            addr_d  = addr_q + 32'd2;
            rec_d   = rec_q >> 16;
            wdata_d = rec_q[31:16];
          end
        end
      end
      default: begin
        state_d = IDLE;
        wr_d    = 1'b0;
      end
    endcase
  end

  assign oready            = (state_q == IDLE);
  assign odone             = done_q;
  assign avm_m0_write      = wr_q;
  assign avm_m0_address    = addr_q;
  assign avm_m0_writedata  = wdata_q;
  assign avm_m0_byteenable = be_q;

`ifdef HIT_WRITER_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else if (done_d) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign o_wr_count = cnt_q;
`else
  assign o_wr_count = '0;
`endif

endmodule

// File: tb/tb_hit_writer.sv
// Randomized and directed bench for hit_writer against a queue-based record model.
module tb_hit_writer;

  localparam int NDWORDS = 3;
  localparam int DW      = 32 * NDWORDS;
  localparam int NHW     = 2 * NDWORDS;
`ifdef HIT_WRITER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          i_clk;
  logic          i_rstn;
  logic [31:0]   baseaddr;
  logic [31:0]   index;
  logic          write;
  logic [DW-1:0] data;
  logic          oready;
  logic          odone;
  logic [31:0]   o_wr_count;
  logic          avm_m0_write;
  logic [31:0]   avm_m0_address;
  logic [15:0]   avm_m0_writedata;
  logic [1:0]    avm_m0_byteenable;
  logic          avm_m0_waitrequest;

  hit_writer #(.NDWORDS(NDWORDS)) dut (
    .i_clk              (i_clk),
    .i_rstn             (i_rstn),
    .baseaddr           (baseaddr),
    .index              (index),
    .write              (write),
    .data               (data),
    .oready             (oready),
    .odone              (odone),
    .o_wr_count         (o_wr_count),
    .avm_m0_write       (avm_m0_write),
    .avm_m0_address     (avm_m0_address),
    .avm_m0_writedata   (avm_m0_writedata),
    .avm_m0_byteenable  (avm_m0_byteenable),
    .avm_m0_waitrequest (avm_m0_waitrequest)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending (address, halfword) pairs of the record in flight.
  logic [31:0] q_addr[$];
  logic [15:0] q_data[$];
  logic [31:0] obs_addr[$];
  logic [15:0] obs_data[$];
  logic [31:0] last_addr;
  logic [15:0] last_data;
  logic        done_pend;
  logic [31:0] exp_cnt;
  int          cyc, acc_cyc, last_lat, n_acc, n_odone;

  logic [31:0] tab_addr[NHW];
  logic [15:0] tab_data[NHW];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_d();
    logic [DW-1:0] r;
    for (int k = 0; k < NDWORDS; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_record(input logic [31:0] b, input logic [31:0] i, input logic [DW-1:0] d);
    logic [31:0] st;
    logic [31:0] dw;
    st = b + i * 32'(NDWORDS * 4);
    for (int h = 0; h < NHW; h++) begin
      dw = d[32*(h/2) +: 32];
      q_addr.push_back(st + 32'(2 * h));
      q_data.push_back((h % 2 == 1) ? dw[31:16] : dw[15:0]);
    end
    n_acc++;
  endtask

  // One clock: check the DUT against the model, then drive the next inputs.
  task automatic cycle(input logic wr, input logic wq, input logic [31:0] b,
                       input logic [31:0] i, input logic [DW-1:0] d);
    @(negedge i_clk);
    cyc++;
    chk("oready", {31'd0, oready}, {31'd0, q_addr.size() == 0});
    chk("odone", {31'd0, odone}, {31'd0, done_pend});
    if (odone === 1'b1) n_odone++;
    if (done_pend) last_lat = cyc - acc_cyc;
    done_pend = 1'b0;
    chk("wr_count", o_wr_count, exp_cnt);
    if (q_addr.size() != 0) begin
      chk("avm_write", {31'd0, avm_m0_write}, 32'd1);
      chk("byteenable", {30'd0, avm_m0_byteenable}, 32'd3);
      chk("address", avm_m0_address, q_addr[0]);
      chk("writedata", {16'd0, avm_m0_writedata}, {16'd0, q_data[0]});
    end else begin
      chk("avm_write_idle", {31'd0, avm_m0_write}, 32'd0);
      chk("addr_hold", avm_m0_address, last_addr);
      chk("data_hold", {16'd0, avm_m0_writedata}, {16'd0, last_data});
    end
    write              = wr;
    avm_m0_waitrequest = wq;
    baseaddr           = b;
    index              = i;
    data               = d;
    if (q_addr.size() != 0) begin
      if (!wq) begin
        obs_addr.push_back(avm_m0_address);
        obs_data.push_back(avm_m0_writedata);
        last_addr = q_addr.pop_front();
        last_data = q_data.pop_front();
        if (q_addr.size() == 0) begin
          done_pend = 1'b1;
          if (CNT_EN) exp_cnt = exp_cnt + 32'd1;
        end
      end
    end else if (wr) begin
      push_record(b, i, d);
      acc_cyc = cyc;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, $urandom, $urandom, rnd_d());
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rstn             = 1'b0;
    write              = 1'b0;
    avm_m0_waitrequest = 1'b0;
    #1;
    chk("rst_write", {31'd0, avm_m0_write}, 32'd0);
    chk("rst_addr", avm_m0_address, 32'd0);
    chk("rst_data", {16'd0, avm_m0_writedata}, 32'd0);
    chk("rst_be", {30'd0, avm_m0_byteenable}, 32'd0);
    chk("rst_odone", {31'd0, odone}, 32'd0);
    chk("rst_oready", {31'd0, oready}, 32'd1);
    chk("rst_cnt", o_wr_count, 32'd0);
    q_addr.delete();
    q_data.delete();
    done_pend = 1'b0;
    exp_cnt   = '0;
    last_addr = '0;
    last_data = '0;
    @(posedge i_clk);
    #2 i_rstn = 1'b1;
  endtask

  task automatic check_obs(input string tag, input bit with_data);
    chk({tag, "_count"}, obs_addr.size(), NHW);
    for (int k = 0; k < NHW && k < obs_addr.size(); k++) begin
      chk({tag, "_addr"}, obs_addr[k], tab_addr[k]);
      if (with_data) chk({tag, "_data"}, {16'd0, obs_data[k]}, {16'd0, tab_data[k]});
    end
    obs_addr.delete();
    obs_data.delete();
  endtask

  logic [DW-1:0] rec_a;

  initial begin
    i_rstn = 1'b0;
    write = 1'b0;
    avm_m0_waitrequest = 1'b0;
    baseaddr = '0;
    index = '0;
    data = '0;
    cyc = 0; acc_cyc = 0; last_lat = 0; n_acc = 0; n_odone = 0;
    do_reset();
    idle_cycles(2);

    rec_a = {32'h0000_0007, 32'h0001_8000, 32'h0000_0001};
    tab_addr = '{32'h1018, 32'h101A, 32'h101C, 32'h101E, 32'h1020, 32'h1022};
    tab_data = '{16'h0001, 16'h0000, 16'h8000, 16'h0001, 16'h0007, 16'h0000};

    // Basic record, no stalls; inputs scrambled after accept.
    obs_addr.delete(); obs_data.delete();
    cycle(1'b1, 1'b0, 32'h1000, 32'd2, rec_a);
    idle_cycles(8);
    check_obs("basic", 1'b1);
    chk("basic_latency", last_lat, 32'd7);

    // Same record, three wait states on halfword 2.
    cycle(1'b1, 1'b0, 32'h1000, 32'd2, rec_a);
    cycle(1'b0, 1'b0, $urandom, $urandom, rnd_d());
    cycle(1'b0, 1'b0, $urandom, $urandom, rnd_d());
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, $urandom, $urandom, rnd_d());
    idle_cycles(6);
    check_obs("stall", 1'b1);
    chk("stall_latency", last_lat, 32'd10);

    // write held high across three records.
    do_reset();
    n_odone = 0; n_acc = 0;
    for (int k = 0; k < 30; k++)
      cycle(n_acc < 3, 1'b0, 32'h2000, $urandom_range(0, 15), rnd_d());
    chk("cont_odone", n_odone, 32'd3);
    chk("cont_writes", obs_addr.size(), 32'd18);
    chk("cont_count", o_wr_count, CNT_EN ? 32'd3 : 32'd0);
    obs_addr.delete(); obs_data.delete();

    // Address wrap at the top of the 32-bit space.
    tab_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFA, 32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0, 32'h2};
    cycle(1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0, rnd_d());
    idle_cycles(8);
    check_obs("wrap", 1'b0);

    // Reset after the second halfword is accepted, then a clean record.
    cycle(1'b1, 1'b0, 32'h1000, 32'd2, rec_a);
    cycle(1'b0, 1'b0, $urandom, $urandom, rnd_d());
    cycle(1'b0, 1'b0, $urandom, $urandom, rnd_d());
    n_odone = 0;
    do_reset();
    idle_cycles(4);
    chk("rst_no_odone", n_odone, 32'd0);
    obs_addr.delete(); obs_data.delete();
    tab_addr = '{32'h1018, 32'h101A, 32'h101C, 32'h101E, 32'h1020, 32'h1022};
    cycle(1'b1, 1'b0, 32'h1000, 32'd2, rec_a);
    idle_cycles(8);
    check_obs("post_rst", 1'b1);
    chk("post_rst_latency", last_lat, 32'd7);

    // Random traffic with random wait states.
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom,
            ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 7)), rnd_d());
    idle_cycles(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
